// File: rtl/mio_pkg.sv
// Shared definitions for the CPU memory/IO bus responder: peripheral
// addresses, FSM states and address-decode targets.
package mio_pkg;

  localparam logic [31:0] SEG7_0_ADDR = 32'hF000_0000;
  localparam logic [31:0] SEG7_1_ADDR = 32'hF000_0004;
  localparam logic [31:0] LED_0_ADDR  = 32'hE000_0000;
  localparam logic [31:0] LED_1_ADDR  = 32'hE000_0004;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM_WAIT,
    ST_RESP
  } state_e;

  typedef enum logic [2:0] {
    TGT_RAM,
    TGT_SEG0,
    TGT_SEG1,
    TGT_LED0,
    TGT_LED1,
    TGT_NONE
  } tgt_e;

endpackage

// File: rtl/mio_addr_decode.sv
// Combinational address decoder: exact peripheral match wins over the RAM
// window; anything else is unmapped. Alignment is reported separately.
module mio_addr_decode
  import mio_pkg::*;
#(
  parameter int RAM_AW = 10
) (
  input  logic [31:0] addr,
  output tgt_e        tgt,
  output logic        aligned
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch can never be inferred.
    tgt = TGT_NONE;
    if (addr == SEG7_0_ADDR) begin
      tgt = TGT_SEG0;
    end else if (addr == SEG7_1_ADDR) begin
      tgt = TGT_SEG1;
    end else if (addr == LED_0_ADDR) begin
      tgt = TGT_LED0;
    end else if (addr == LED_1_ADDR) begin
      tgt = TGT_LED1;
    end else if ((addr >> (RAM_AW + 2)) == 32'd0) begin
      tgt = TGT_RAM;
    end
  end

  assign aligned = (addr[1:0] == 2'b00);

endmodule

// File: rtl/mio_bus_responder.sv
// Responder end of the CPU memory/IO bus: one request at a time, answered
// with a single-cycle mio_ready pulse; serves a sync-read RAM and 4 registers.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int          RAM_AW        = 10,
  parameter int          WAIT_STATES   = 1,
  parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_mio,
  input  logic              mem_w,
  input  logic [31:0]       addr,
  input  logic [31:0]       data_from_cpu,
  output logic [31:0]       data_to_cpu,
  output logic              mio_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  output logic [31:0]       seg7_0,
  output logic [31:0]       seg7_1,
  output logic [31:0]       led_0,
  output logic [31:0]       led_1,
  output logic              bus_err
);

  localparam logic [WAIT_CNT_W-1:0] WS = WAIT_CNT_W'(WAIT_STATES);

  tgt_e dec_tgt;
  logic dec_aligned;

  mio_addr_decode #(.RAM_AW(RAM_AW)) u_decode (
    .addr    (addr),
    .tgt     (dec_tgt),
    .aligned (dec_aligned)
  );

  state_e                state_q,     state_d;
  logic [WAIT_CNT_W-1:0] cnt_q,       cnt_d;
  logic [RAM_AW-1:0]     ram_addr_q,  ram_addr_d;
  logic [31:0]           wdata_q,     wdata_d;
  logic                  is_write_q,  is_write_d;
  logic                  ram_we_q,    ram_we_d;
  logic                  mio_ready_q, mio_ready_d;
  logic                  bus_err_q,   bus_err_d;
  logic [31:0]           rdata_q,     rdata_d;
  logic [31:0]           seg0_q,      seg0_d;
  logic [31:0]           seg1_q,      seg1_d;
  logic [31:0]           led0_q,      led0_d;
  logic [31:0]           led1_q,      led1_d;

  tgt_e eff_tgt;
  assign eff_tgt = dec_aligned ? dec_tgt : TGT_NONE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_addr_d  = ram_addr_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    ram_we_d    = 1'b0;
    mio_ready_d = 1'b0;
    bus_err_d   = 1'b0;
    rdata_d     = rdata_q;
    seg0_d      = seg0_q;
    seg1_d      = seg1_q;
    led0_d      = led0_q;
    led1_d      = led1_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_mio) begin
          ram_addr_d = addr[RAM_AW+1:2];
          wdata_d    = data_from_cpu;
          is_write_d = mem_w;
          if (eff_tgt == TGT_RAM) begin
            state_d  = ST_RAM_WAIT;
            cnt_d    = WS;
            ram_we_d = mem_w;
          end else begin
            state_d     = ST_RESP;
            mio_ready_d = 1'b1;
            unique case (eff_tgt)
              TGT_SEG0: if (mem_w) seg0_d = data_from_cpu; else rdata_d = seg0_q;
              TGT_SEG1: if (mem_w) seg1_d = data_from_cpu; else rdata_d = seg1_q;
              TGT_LED0: if (mem_w) led0_d = data_from_cpu; else rdata_d = led0_q;
              TGT_LED1: if (mem_w) led1_d = data_from_cpu; else rdata_d = led1_q;
              default: begin
                bus_err_d = 1'b1;
                if (!mem_w) rdata_d = UNMAPPED_DATA;
              end
            endcase
          end
        end
      end
      ST_RAM_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          mio_ready_d = 1'b1;
          if (!is_write_q) rdata_d = ram_dout;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ram_addr_q  <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      mio_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      rdata_q     <= '0;
      seg0_q      <= '0;
      seg1_q      <= '0;
      led0_q      <= '0;
      led1_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ram_addr_q  <= ram_addr_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      ram_we_q    <= ram_we_d;
      mio_ready_q <= mio_ready_d;
      bus_err_q   <= bus_err_d;
      rdata_q     <= rdata_d;
      seg0_q      <= seg0_d;
      seg1_q      <= seg1_d;
      led0_q      <= led0_d;
      led1_q      <= led1_d;
    end
  end

  // In IDLE the RAM sees the live address so its synchronous read starts at
  // the accept edge; afterwards it sees the latched request.
  assign ram_addr    = (state_q == ST_IDLE) ? addr[RAM_AW+1:2] : ram_addr_q;
  assign ram_din     = wdata_q;
  assign ram_we      = ram_we_q;
  assign mio_ready   = mio_ready_q;
  assign bus_err     = bus_err_q;
  assign data_to_cpu = rdata_q;
  assign seg7_0      = seg0_q;
  assign seg7_1      = seg1_q;
  assign led_0       = led0_q;
  assign led_1       = led1_q;

endmodule
